// File: rtl/spi_slave_if.sv
// SPI slave front end for the single-port RAM: deserialises MOSI into {cmd, payload} words
// and shifts the RAM's read byte back out on MISO, one SPI bit per system clock.
module spi_slave_if #(
  parameter int unsigned FRAME_W = 10,
  parameter int unsigned TX_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               MOSI,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [TX_W-1:0]    tx_data,
  input  logic               tx_valid
);

  localparam int unsigned CntW = $clog2(FRAME_W + TX_W);

  typedef enum logic [2:0] {
    StIdle,
    StChkCmd,
    StWrite,
    StReadAdd,
    StReadData,
    StWaitTx,
    StShiftOut,
    StDone
  } state_t;

  state_t             r_state, w_state_d;
  logic [CntW-1:0]    r_cnt, w_cnt_d;
  logic [FRAME_W-2:0] r_rx_shift, w_rx_shift_d;
  logic [FRAME_W-1:0] r_rx_data, w_rx_data_d;
  logic               r_rx_valid, w_rx_valid_d;
  logic [TX_W-1:0]    r_tx_shift, w_tx_shift_d;
  logic               r_miso, w_miso_d;
  logic               r_rd_addr_seen, w_rd_addr_seen_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StIdle;
      r_cnt          <= '0;
      r_rx_shift     <= '0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_tx_shift     <= '0;
      r_miso         <= 1'b0;
      r_rd_addr_seen <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_cnt          <= w_cnt_d;
      r_rx_shift     <= w_rx_shift_d;
      r_rx_data      <= w_rx_data_d;
      r_rx_valid     <= w_rx_valid_d;
      r_tx_shift     <= w_tx_shift_d;
      r_miso         <= w_miso_d;
      r_rd_addr_seen <= w_rd_addr_seen_d;
    end
  end

  always_comb begin
    w_state_d        = r_state;
    w_cnt_d          = r_cnt;
    w_rx_shift_d     = r_rx_shift;
    w_rx_data_d      = r_rx_data;
    w_rx_valid_d     = 1'b0;
    w_tx_shift_d     = r_tx_shift;
    w_miso_d         = r_miso;
    w_rd_addr_seen_d = r_rd_addr_seen;

    if (SS_n) begin
      // Deselect wins over everything; a partial word is simply dropped.
      w_state_d = StIdle;
      w_cnt_d   = '0;
      w_miso_d  = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_state_d = StChkCmd;
          w_cnt_d   = '0;
        end
        StChkCmd: begin
          w_cnt_d = '0;
          if (!MOSI)               w_state_d = StWrite;
          else if (r_rd_addr_seen) w_state_d = StReadData;
          else                     w_state_d = StReadAdd;
        end
        StWrite, StReadAdd, StReadData: begin
          w_rx_shift_d = {r_rx_shift[FRAME_W-3:0], MOSI};
          w_cnt_d      = r_cnt + 1'b1;
          if (r_cnt == CntW'(FRAME_W - 1)) begin
            w_rx_data_d  = {r_rx_shift, MOSI};
            w_rx_valid_d = 1'b1;
            w_cnt_d      = '0;
            w_state_d    = StDone;
            if (r_state == StReadAdd) w_rd_addr_seen_d = 1'b1;
            if (r_state == StReadData) begin
              w_rd_addr_seen_d = 1'b0;
              w_state_d        = StWaitTx;
            end
          end
        end
        StWaitTx: begin
          if (tx_valid) begin
            // MSB goes straight to MISO; the shifter keeps the remaining bits, MSB-aligned.
            w_miso_d     = tx_data[TX_W-1];
            w_tx_shift_d = {tx_data[TX_W-2:0], 1'b0};
            w_cnt_d      = '0;
            w_state_d    = StShiftOut;
          end
        end
        StShiftOut: begin
          if (r_cnt == CntW'(TX_W - 1)) begin
            w_miso_d  = 1'b0;
            w_cnt_d   = '0;
            w_state_d = StDone;
          end else begin
            w_miso_d     = r_tx_shift[TX_W-1];
            w_tx_shift_d = r_tx_shift << 1;
            w_cnt_d      = r_cnt + 1'b1;
          end
        end
        StDone: begin
          w_miso_d = 1'b0;
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  assign MISO     = r_miso;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: write, read-address, read-data with MISO shifting, abort,
// asynchronous reset mid-frame and a tx_valid that is already high when the read byte is wanted.
module tb_spi_slave_if;

  logic       clk;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int n_total;
  int n_bad;

  logic [2:0] w_st;
  logic       w_seen;

  spi_slave_if #(
    .FRAME_W(10),
    .TX_W   (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SS_n    (SS_n),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_valid(tx_valid)
  );

  assign w_st   = dut.r_state;
  assign w_seen = dut.r_rd_addr_seen;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full frame: SS_n low (edge 0), cmd (edge 1), 10 bits (edges 2..11). Returns just after
  // edge 11, where rx_valid must be high.
  task automatic frame(input string tag, input logic cmd, input logic [9:0] w);
    logic early_valid;
    logic miso_seen;
    early_valid = 1'b0;
    miso_seen   = 1'b0;
    SS_n = 1'b0;
    step();
    MOSI = cmd;
    step();
    for (int i = 9; i >= 0; i--) begin
      early_valid |= rx_valid;
      miso_seen   |= MISO;
      MOSI = w[i];
      step();
    end
    chk({tag, "_early_valid"}, 32'(early_valid), 32'd0);
    chk({tag, "_miso_quiet"}, 32'(miso_seen), 32'd0);
    chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd1);
    chk({tag, "_rx_data"}, 32'(rx_data), 32'(w));
  endtask

  task automatic deselect();
    SS_n = 1'b1;
    MOSI = 1'b0;
    step();
  endtask

  logic [7:0] a5;
  logic [7:0] c3;
  int         extra;

  initial begin
    n_total  = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    a5       = 8'hA5;
    c3       = 8'hC3;

    #12;
    chk("rst_miso", 32'(MISO), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_state", 32'(w_st), 32'd0);
    chk("rst_seen", 32'(w_seen), 32'd0);
    rst_n = 1'b1;
    step();

    // 1. write address
    frame("wr_addr", 1'b0, 10'h005);
    step();
    chk("wr_addr_pulse_end", 32'(rx_valid), 32'd0);
    chk("wr_addr_seen", 32'(w_seen), 32'd0);
    chk("wr_addr_done_miso", 32'(MISO), 32'd0);
    deselect();

    // 2. write data; extra MOSI ones after the word must not produce another pulse
    frame("wr_data", 1'b0, 10'h1AA);
    extra = 0;
    MOSI  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      extra += int'(rx_valid);
    end
    chk("wr_data_extra_pulses", 32'(extra), 32'd0);
    chk("wr_data_hold", 32'(rx_data), 32'h1AA);
    deselect();

    // 3. read address
    frame("rd_addr", 1'b1, 10'h205);
    chk("rd_addr_seen", 32'(w_seen), 32'd1);
    deselect();

    // 4. read data, then the byte 0xA5 shifted out MSB first
    frame("rd_data", 1'b1, 10'h300);
    chk("rd_data_seen_clr", 32'(w_seen), 32'd0);
    step();
    chk("rd_wait_miso", 32'(MISO), 32'd0);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      step();
      chk("rd_miso_bit", 32'(MISO), 32'(a5[i]));
      if (i == 7) begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
      end
    end
    step();
    chk("rd_miso_after", 32'(MISO), 32'd0);
    step();
    chk("rd_miso_done", 32'(MISO), 32'd0);
    deselect();

    // 5. abort a write after 5 data bits
    SS_n = 1'b0;
    step();
    MOSI = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      MOSI = 1'b1;
      step();
    end
    SS_n = 1'b1;
    step();
    chk("abort_state", 32'(w_st), 32'd0);
    chk("abort_valid", 32'(rx_valid), 32'd0);
    step();
    chk("abort_valid_late", 32'(rx_valid), 32'd0);
    frame("post_abort", 1'b0, 10'h0F0);
    chk("post_abort_seen", 32'(w_seen), 32'd0);
    deselect();

    // 6a. reset in the middle of a READ_DATA frame
    frame("pre_rst", 1'b1, 10'h2AB);
    deselect();
    SS_n = 1'b0;
    step();
    MOSI = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      MOSI = ~MOSI;
      step();
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rx_data", 32'(rx_data), 32'd0);
    chk("mid_rst_valid", 32'(rx_valid), 32'd0);
    chk("mid_rst_miso", 32'(MISO), 32'd0);
    chk("mid_rst_seen", 32'(w_seen), 32'd0);
    chk("mid_rst_state", 32'(w_st), 32'd0);
    rst_n = 1'b1;
    deselect();

    // 6b. tx_valid stuck high: byte taken on the first WAIT_TX edge
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    frame("stuck_addr", 1'b1, 10'h001);
    deselect();
    frame("stuck_data", 1'b1, 10'h3C0);
    for (int i = 7; i >= 5; i--) begin
      step();
      chk("stuck_miso_bit", 32'(MISO), 32'(c3[i]));
    end
    deselect();
    tx_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
